// File: rtl/msx_mem_arbiter.sv
// msx_mem_arbiter
// Shares the single SDRAM port between the ioctl download path (DL), the CPU
// slot/mapper path (CPU) and the FDC/device path (DEV). One transaction is in
// flight at a time: IDLE samples the requests, BUSY holds sdram_req until the
// controller acknowledges (or the ack watchdog expires), DONE pulses the ack
// of the requester that owned the cycle.
//
// Optional feature: define MSX_MEM_BOUNDS_CHECK_EN to reject CPU accesses
// whose page (cpu_offset[26:14]) lies beyond cpu_size. Without it only the
// read-only write protection is applied.

module msx_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_req,
    input  logic        dl_we,
    input  logic [26:0] dl_addr,
    input  logic [7:0]  dl_wdata,
    output logic        dl_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [26:0] cpu_addr,
    input  logic [26:0] cpu_offset,
    input  logic [15:0] cpu_size,
    input  logic        cpu_ro,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dev_req,
    input  logic        dev_we,
    input  logic [26:0] dev_addr,
    input  logic        dev_ro,
    input  logic [7:0]  dev_wdata,
    output logic        dev_ack,
    output logic [7:0]  dev_rdata,
    output logic        sdram_req,
    output logic        sdram_we,
    output logic [26:0] sdram_addr,
    output logic [7:0]  sdram_din,
    input  logic        sdram_ack,
    input  logic [7:0]  sdram_dout,
    output logic        err_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OWN_DL  = 2'd0;
    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_DEV = 2'd2;

    localparam logic [3:0] STARVE_MAX    = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST      = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] RDATA_BLOCKED = 8'hFF;

    // A write into a read-only region never reaches the SDRAM.
    function automatic logic f_write_protected(input logic we, input logic ro);
        return we & ro;
    endfunction

`ifdef MSX_MEM_BOUNDS_CHECK_EN
    // Region sizes are counted in 16 KB pages, so only the page number matters.
    function automatic logic f_out_of_range(input logic [12:0] page, input logic [15:0] size);
        return ({3'b000, page} >= size);
    endfunction
`endif

    logic [1:0]  r_state;
    logic [1:0]  r_owner;
    logic [3:0]  r_starve;
    logic [7:0]  r_tmo;
    logic        r_sdram_req;
    logic        r_sdram_we;
    logic [26:0] r_sdram_addr;
    logic [7:0]  r_sdram_din;
    logic        r_dl_ack;
    logic        r_cpu_ack;
    logic        r_dev_ack;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_dev_rdata;
    logic        r_err_timeout;

    logic        w_idle;
    logic        w_grant_dl;
    logic        w_grant_cpu;
    logic        w_grant_dev;
    logic        w_cpu_blocked;
    logic        w_dev_blocked;
    logic        w_busy_end;
    logic        w_timeout;
    logic [7:0]  w_end_rdata;

    assign w_idle = (r_state == ST_IDLE);

`ifdef MSX_MEM_BOUNDS_CHECK_EN
    logic w_unused_offset_lo;
    assign w_unused_offset_lo = ^cpu_offset[13:0];
    assign w_cpu_blocked = f_write_protected(cpu_we, cpu_ro)
                         | f_out_of_range(cpu_offset[26:14], cpu_size);
`else
    logic w_unused_bounds;
    assign w_unused_bounds = ^{cpu_offset, cpu_size};
    assign w_cpu_blocked = f_write_protected(cpu_we, cpu_ro);
`endif
    assign w_dev_blocked = f_write_protected(dev_we, dev_ro);

    // Grant selection: DL first, DEV jumps CPU once it has starved long enough.
    always_comb begin
        w_grant_dl  = 1'b0;
        w_grant_cpu = 1'b0;
        w_grant_dev = 1'b0;
        if (!w_idle) begin
            w_grant_dl = 1'b0;
        end else if (dl_req) begin
            w_grant_dl = 1'b1;
        end else if (dev_req && (r_starve == STARVE_MAX)) begin
            w_grant_dev = 1'b1;
        end else if (cpu_req) begin
            w_grant_cpu = 1'b1;
        end else if (dev_req) begin
            w_grant_dev = 1'b1;
        end else begin
            w_grant_dl = 1'b0;
        end
    end

    // End of a BUSY cycle: a real ack beats a watchdog expiry in the same cycle.
    always_comb begin
        w_busy_end  = 1'b0;
        w_timeout   = 1'b0;
        w_end_rdata = RDATA_BLOCKED;
        if ((r_state == ST_BUSY) && sdram_ack) begin
            w_busy_end  = 1'b1;
            w_end_rdata = sdram_dout;
        end else if ((r_state == ST_BUSY) && (r_tmo == TMO_LAST)) begin
            w_busy_end  = 1'b1;
            w_timeout   = 1'b1;
        end else begin
            w_busy_end  = 1'b0;
        end
    end

    // Transaction FSM: latch the winner, run the SDRAM handshake, pulse the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_DL;
            r_tmo         <= 8'd0;
            r_sdram_req   <= 1'b0;
            r_sdram_we    <= 1'b0;
            r_sdram_addr  <= 27'd0;
            r_sdram_din   <= 8'd0;
            r_dl_ack      <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_dev_ack     <= 1'b0;
            r_cpu_rdata   <= 8'd0;
            r_dev_rdata   <= 8'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_dl_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dev_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dl) begin
                        r_owner      <= OWN_DL;
                        r_sdram_addr <= dl_addr;
                        r_sdram_we   <= dl_we;
                        r_sdram_din  <= dl_wdata;
                        r_sdram_req  <= 1'b1;
                        r_tmo        <= 8'd0;
                        r_state      <= ST_BUSY;
                    end else if (w_grant_cpu) begin
                        r_owner <= OWN_CPU;
                        if (w_cpu_blocked) begin
                            r_cpu_ack   <= 1'b1;
                            r_cpu_rdata <= RDATA_BLOCKED;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sdram_addr <= cpu_addr;
                            r_sdram_we   <= cpu_we;
                            r_sdram_din  <= cpu_wdata;
                            r_sdram_req  <= 1'b1;
                            r_tmo        <= 8'd0;
                            r_state      <= ST_BUSY;
                        end
                    end else if (w_grant_dev) begin
                        r_owner <= OWN_DEV;
                        if (w_dev_blocked) begin
                            r_dev_ack   <= 1'b1;
                            r_dev_rdata <= RDATA_BLOCKED;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sdram_addr <= dev_addr;
                            r_sdram_we   <= dev_we;
                            r_sdram_din  <= dev_wdata;
                            r_sdram_req  <= 1'b1;
                            r_tmo        <= 8'd0;
                            r_state      <= ST_BUSY;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_busy_end) begin
                        r_sdram_req <= 1'b0;
                        r_state     <= ST_DONE;
                        if (w_timeout) begin
                            r_err_timeout <= 1'b1;
                        end
                        case (r_owner)
                            OWN_DL:  r_dl_ack <= 1'b1;
                            OWN_CPU: begin
                                r_cpu_ack   <= 1'b1;
                                r_cpu_rdata <= w_end_rdata;
                            end
                            OWN_DEV: begin
                                r_dev_ack   <= 1'b1;
                                r_dev_rdata <= w_end_rdata;
                            end
                            default: r_dl_ack <= 1'b0;
                        endcase
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sdram_req <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts CPU wins that left DEV waiting, cleared by a DEV win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= 4'd0;
        end else if (w_grant_dev) begin
            r_starve <= 4'd0;
        end else if (w_grant_cpu && dev_req && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign dl_ack      = r_dl_ack;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign dev_ack     = r_dev_ack;
    assign dev_rdata   = r_dev_rdata;
    assign sdram_req   = r_sdram_req;
    assign sdram_we    = r_sdram_we;
    assign sdram_addr  = r_sdram_addr;
    assign sdram_din   = r_sdram_din;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// Directed bench for msx_mem_arbiter with a behavioural SDRAM responder and
// two scoreboards: expected SDRAM cycles and expected completion acks.
module tb_msx_mem_arbiter;

    localparam logic [1:0] OWN_DL  = 2'd0;
    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_DEV = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_req, dl_we;
    logic [26:0] dl_addr;
    logic [7:0]  dl_wdata;
    logic        dl_ack;
    logic        cpu_req, cpu_we, cpu_ro;
    logic [26:0] cpu_addr, cpu_offset;
    logic [15:0] cpu_size;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        dev_req, dev_we, dev_ro;
    logic [26:0] dev_addr;
    logic [7:0]  dev_wdata, dev_rdata;
    logic        dev_ack;
    logic        sdram_req, sdram_we, sdram_ack;
    logic [26:0] sdram_addr;
    logic [7:0]  sdram_din, sdram_dout;
    logic        err_timeout;

    typedef struct {
        logic [26:0] addr;
        logic        we;
        logic [7:0]  din;
        int          len;
    } sd_exp_t;

    typedef struct {
        logic [1:0] owner;
        logic       chk_rd;
        logic [7:0] rdata;
        int         req_cyc;
        int         lat;
    } ack_exp_t;

    sd_exp_t  exp_sd[$];
    ack_exp_t exp_ack[$];
    sd_exp_t  cur_sd;
    logic     cur_valid = 1'b0;
    int       req_len   = 0;
    logic     prev_req  = 1'b0;
    logic [7:0] mem [int unsigned];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dl_left = 0, cpu_left = 0, dev_left = 0;
    int sd_lat = 2;
    int sd_cnt = 0;
    logic sd_hold = 1'b0;

    msx_mem_arbiter #(.STARVE_LIMIT(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_we(dl_we), .dl_addr(dl_addr), .dl_wdata(dl_wdata), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_offset(cpu_offset),
        .cpu_size(cpu_size), .cpu_ro(cpu_ro), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_ro(dev_ro),
        .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_dout(sdram_dout),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_model(input logic [26:0] a);
        if (mem.exists({5'd0, a})) return mem[{5'd0, a}];
        else return a[7:0] ^ 8'hA5;
    endfunction

    task automatic push_sd(input logic [26:0] a, input logic we, input logic [7:0] d, input int len);
        sd_exp_t e;
        e.addr = a; e.we = we; e.din = d; e.len = len;
        exp_sd.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] own, input logic chk_rd, input logic [7:0] rd, input int lat);
        ack_exp_t e;
        e.owner = own; e.chk_rd = chk_rd; e.rdata = rd; e.req_cyc = cyc; e.lat = lat;
        exp_ack.push_back(e);
    endtask

    // One clock: advance, then at the falling edge check outputs and run the SDRAM model.
    task automatic tick();
        logic [2:0] acks;
        logic [2:0] exp_oh;
        ack_exp_t   e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sdram_req && !prev_req) begin
            if (exp_sd.size() == 0) begin
                chk("sd_unexpected", 64'(sdram_addr), 64'h7FFFFFFFF);
            end else begin
                cur_sd = exp_sd.pop_front();
                chk("sd_cmd", 64'({sdram_addr, sdram_we, sdram_din}),
                    64'({cur_sd.addr, cur_sd.we, cur_sd.din}));
                cur_valid = 1'b1;
                req_len = 0;
            end
        end
        if (sdram_req) req_len++;
        if (!sdram_req && prev_req && cur_valid) begin
            chk("sd_req_len", 64'(req_len), 64'(cur_sd.len));
            cur_valid = 1'b0;
        end
        prev_req = sdram_req;
        acks = {dl_ack, cpu_ack, dev_ack};
        if (acks != 3'b000) begin
            if (exp_ack.size() == 0) begin
                chk("ack_unexpected", 64'(acks), 64'd0);
            end else begin
                e = exp_ack.pop_front();
                exp_oh = (e.owner == OWN_DL) ? 3'b100 : (e.owner == OWN_CPU) ? 3'b010 : 3'b001;
                chk("ack_owner", 64'(acks), 64'(exp_oh));
                if (e.chk_rd)
                    chk("ack_rdata", 64'((e.owner == OWN_CPU) ? cpu_rdata : dev_rdata), 64'(e.rdata));
                if (e.lat != 0)
                    chk("ack_latency", 64'(cyc - e.req_cyc), 64'(e.lat));
            end
            if (dl_ack)  begin dl_left--;  if (dl_left <= 0)  dl_req  = 1'b0; end
            if (cpu_ack) begin cpu_left--; if (cpu_left <= 0) cpu_req = 1'b0; end
            if (dev_ack) begin dev_left--; if (dev_left <= 0) dev_req = 1'b0; end
        end
        if (sdram_ack) begin
            sdram_ack = 1'b0;
            sd_cnt = 0;
        end else if (sdram_req && !sd_hold) begin
            sd_cnt++;
            if (sd_cnt == sd_lat) begin
                sdram_ack = 1'b1;
                if (sdram_we) begin
                    mem[{5'd0, sdram_addr}] = sdram_din;
                    sdram_dout = 8'hC3;
                end else begin
                    sdram_dout = rd_model(sdram_addr);
                end
            end
        end else begin
            sd_cnt = 0;
        end
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while ((exp_sd.size() != 0 || exp_ack.size() != 0 || cur_valid) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $error("FAIL wait_done: observed %0d pending expected 0", exp_sd.size() + exp_ack.size());
            exp_sd.delete();
            exp_ack.delete();
            cur_valid = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic req_cpu(input logic [26:0] a, input logic we, input logic [7:0] d, input logic ro, input int left);
        cpu_addr = a; cpu_we = we; cpu_wdata = d; cpu_ro = ro; cpu_left = left; cpu_req = 1'b1;
    endtask

    task automatic req_dev(input logic [26:0] a, input logic we, input logic [7:0] d, input logic ro, input int left);
        dev_addr = a; dev_we = we; dev_wdata = d; dev_ro = ro; dev_left = left; dev_req = 1'b1;
    endtask

    task automatic req_dl(input logic [26:0] a, input logic we, input logic [7:0] d, input int left);
        dl_addr = a; dl_we = we; dl_wdata = d; dl_left = left; dl_req = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        dl_req = 1'b0; dl_we = 1'b0; dl_addr = 27'd0; dl_wdata = 8'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 27'd0; cpu_offset = 27'd0;
        cpu_size = 16'hFFFF; cpu_ro = 1'b0; cpu_wdata = 8'd0;
        dev_req = 1'b0; dev_we = 1'b0; dev_addr = 27'd0; dev_ro = 1'b0; dev_wdata = 8'd0;
        sdram_ack = 1'b0; sdram_dout = 8'd0;
        mem[32'h0123456] = 8'h5A;
        tick();
        tick();
        chk("reset_outputs", 64'({sdram_req, sdram_we, sdram_addr, sdram_din, dl_ack, cpu_ack,
            dev_ack, cpu_rdata, dev_rdata, err_timeout}), 64'd0);
        reset_n = 1'b1;
        tick();

        // All three request together: DL, then CPU, then DEV
        req_dl(27'h0010000, 1'b1, 8'h11, 1);
        req_cpu(27'h0020000, 1'b0, 8'h00, 1'b0, 1);
        req_dev(27'h0030000, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0010000, 1'b1, 8'h11, 2);
        push_sd(27'h0020000, 1'b0, 8'h00, 2);
        push_sd(27'h0030000, 1'b0, 8'h00, 2);
        push_ack(OWN_DL, 1'b0, 8'h00, 3);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0020000), 0);
        push_ack(OWN_DEV, 1'b1, rd_model(27'h0030000), 0);
        wait_done(60);
        chk("dl_write_mem", 64'(mem[32'h0010000]), 64'h11);

        // Starvation: four CPU wins with DEV waiting, then DEV must win
        req_cpu(27'h0200000, 1'b0, 8'h00, 1'b0, 5);
        req_dev(27'h0300000, 1'b0, 8'h00, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            push_sd(27'h0200000, 1'b0, 8'h00, 2);
            push_ack(OWN_CPU, 1'b1, rd_model(27'h0200000), 0);
        end
        push_sd(27'h0300000, 1'b0, 8'h00, 2);
        push_ack(OWN_DEV, 1'b1, rd_model(27'h0300000), 0);
        push_sd(27'h0200000, 1'b0, 8'h00, 2);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0200000), 0);
        wait_done(120);

        // Counter cleared by the DEV win: CPU wins again on a tie
        req_cpu(27'h0200100, 1'b0, 8'h00, 1'b0, 1);
        req_dev(27'h0300100, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0200100, 1'b0, 8'h00, 2);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0200100), 0);
        push_sd(27'h0300100, 1'b0, 8'h00, 2);
        push_ack(OWN_DEV, 1'b1, rd_model(27'h0300100), 0);
        wait_done(60);

        // Protected CPU write: no SDRAM cycle, ack one cycle later
        req_cpu(27'h0004000, 1'b1, 8'h99, 1'b1, 1);
        push_ack(OWN_CPU, 1'b1, 8'hFF, 1);
        wait_done(20);
        chk("ro_mem_untouched", 64'(mem.exists(32'h0004000)), 64'd0);

        // Protected DEV write, then an ordinary DEV write
        req_dev(27'h0300040, 1'b1, 8'hE7, 1'b1, 1);
        push_ack(OWN_DEV, 1'b1, 8'hFF, 1);
        wait_done(20);
        req_dev(27'h0300040, 1'b1, 8'hE7, 1'b0, 1);
        push_sd(27'h0300040, 1'b1, 8'hE7, 2);
        push_ack(OWN_DEV, 1'b0, 8'h00, 3);
        wait_done(20);
        chk("dev_write_mem", 64'(mem[32'h0300040]), 64'hE7);

        // CPU read with a 7-cycle SDRAM latency
        sd_lat = 7;
        req_cpu(27'h0123456, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0123456, 1'b0, 8'h00, 7);
        push_ack(OWN_CPU, 1'b1, 8'h5A, 8);
        wait_done(40);

        // Stray sdram_ack while idle is ignored
        sdram_ack = 1'b1;
        sdram_dout = 8'h77;
        tick();
        tick();
        chk("stray_ack_ignored", 64'({sdram_req, dl_ack, cpu_ack, dev_ack, cpu_rdata}), 64'h5A);

        // Ack arriving in the last watchdog cycle wins; data valid, no error
        sd_lat = 16;
        req_dev(27'h0300200, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0300200, 1'b0, 8'h00, 16);
        push_ack(OWN_DEV, 1'b1, rd_model(27'h0300200), 17);
        wait_done(60);
        chk("tie_no_timeout", 64'(err_timeout), 64'd0);

        // Withheld ack: watchdog aborts after 16 BUSY cycles
        sd_hold = 1'b1;
        req_cpu(27'h0000100, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0000100, 1'b0, 8'h00, 16);
        push_ack(OWN_CPU, 1'b1, 8'hFF, 17);
        wait_done(60);
        chk("timeout_flag", 64'(err_timeout), 64'd1);
        sd_hold = 1'b0;
        sd_lat = 2;

        // Sticky error survives a later good access
        req_cpu(27'h0000200, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0000200, 1'b0, 8'h00, 2);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0000200), 3);
        wait_done(20);
        chk("timeout_sticky", 64'(err_timeout), 64'd1);

        // Bounds check around a two-page region
        cpu_size = 16'd2;
        cpu_offset = 27'h0008000;
`ifdef MSX_MEM_BOUNDS_CHECK_EN
        req_cpu(27'h0508000, 1'b0, 8'h00, 1'b0, 1);
        push_ack(OWN_CPU, 1'b1, 8'hFF, 1);
        wait_done(20);
        cpu_size = 16'd0;
        cpu_offset = 27'h0000000;
        req_cpu(27'h0500000, 1'b0, 8'h00, 1'b0, 1);
        push_ack(OWN_CPU, 1'b1, 8'hFF, 1);
        wait_done(20);
        cpu_size = 16'd2;
`else
        req_cpu(27'h0508000, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0508000, 1'b0, 8'h00, 2);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0508000), 3);
        wait_done(20);
`endif
        cpu_offset = 27'h0007FFF;
        req_cpu(27'h0507FFF, 1'b0, 8'h00, 1'b0, 1);
        push_sd(27'h0507FFF, 1'b0, 8'h00, 2);
        push_ack(OWN_CPU, 1'b1, rd_model(27'h0507FFF), 3);
        wait_done(20);
        cpu_size = 16'hFFFF;
        cpu_offset = 27'd0;

        // Asynchronous reset in the middle of a BUSY cycle
        sd_hold = 1'b1;
        req_dl(27'h0400000, 1'b0, 8'h00, 1);
        push_sd(27'h0400000, 1'b0, 8'h00, 0);
        tick();
        tick();
        tick();
        chk("busy_before_reset", 64'(sdram_req), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({sdram_req, sdram_we, sdram_addr, sdram_din, dl_ack, cpu_ack,
            dev_ack, cpu_rdata, dev_rdata, err_timeout}), 64'd0);
        exp_sd.delete();
        exp_ack.delete();
        cur_valid = 1'b0;
        dl_req = 1'b0;
        sd_hold = 1'b0;
        sdram_ack = 1'b0;
        sd_cnt = 0;
        tick();
        prev_req = sdram_req;
        reset_n = 1'b1;
        tick();
        req_dl(27'h0400010, 1'b1, 8'h3C, 1);
        push_sd(27'h0400010, 1'b1, 8'h3C, 2);
        push_ack(OWN_DL, 1'b0, 8'h00, 3);
        wait_done(20);
        chk("post_reset_dl_mem", 64'(mem[32'h0400010]), 64'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
